// File: rtl/sram_port_arbiter_pkg.sv
// Shared encodings and the request payload for the sram port arbiter.
package sram_port_arbiter_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned SIZE_W = 2;
   localparam int unsigned STRB_W = 4;

   localparam logic ID_INST = 1'b0;
   localparam logic ID_DATA = 1'b1;

   localparam logic [SIZE_W-1:0] SIZE_WORD = 2'b10;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   typedef struct packed {
      logic              wr;
      logic [SIZE_W-1:0] size;
      logic [STRB_W-1:0] wstrb;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } mem_req_t;

endpackage

// File: rtl/sram_port_arbiter_resp_id_fifo.sv
// In-order owner-ID FIFO: one entry per accepted address phase, popped per response.
module resp_id_fifo #(
   parameter int unsigned DEPTH = 2
) (
   input  logic clk,
   input  logic resetn,
   input  logic push,
   input  logic pop,
   input  logic din,
   output logic dout,
   output logic full,
   output logic empty
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic             mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: entries are only read once counted in.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one sram-like port between the instruction and data requesters,
// holding a granted request until accepted and routing in-order responses.
module sram_port_arbiter
   import sram_port_arbiter_pkg::*;
#(
   parameter int unsigned OUTSTANDING = 2
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              inst_req,
   input  logic [ADDR_W-1:0] inst_addr,
   output logic              inst_addr_ok,
   output logic              inst_data_ok,
   output logic [DATA_W-1:0] inst_rdata,
   input  logic              data_req,
   input  logic              data_wr,
   input  logic [SIZE_W-1:0] data_size,
   input  logic [STRB_W-1:0] data_wstrb,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic [DATA_W-1:0] data_wdata,
   output logic              data_addr_ok,
   output logic              data_data_ok,
   output logic [DATA_W-1:0] data_rdata,
   output logic              mem_req,
   output logic              mem_wr,
   output logic [SIZE_W-1:0] mem_size,
   output logic [STRB_W-1:0] mem_wstrb,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_addr_ok,
   input  logic              mem_data_ok,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              resp_err
);

   state_t   state_q, state_d;
   logic     owner_q, owner_d;
   logic     owner_req;
   logic     grant;
   logic     sel;
   logic     push;
   logic     pop;
   logic     fifo_dout;
   logic     fifo_full;
   logic     fifo_empty;
   mem_req_t req_inst;
   mem_req_t req_data;
   mem_req_t req_out;

   assign req_inst = '{wr: 1'b0, size: SIZE_WORD, wstrb: '0, addr: inst_addr, wdata: '0};
   assign req_data = '{wr: data_wr, size: data_size, wstrb: data_wstrb,
                       addr: data_addr, wdata: data_wdata};

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         owner_q <= ID_INST;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
      end
   end

   // Grant FSM: data wins in IDLE; HOLD freezes the owner until accepted.
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      grant     = 1'b0;
      sel       = ID_INST;
      owner_req = (owner_q == ID_DATA) ? data_req : inst_req;
      if (resetn) begin
         case (state_q)
            ST_IDLE: begin
               if (!fifo_full && (data_req || inst_req)) begin
                  grant = 1'b1;
                  sel   = data_req ? ID_DATA : ID_INST;
                  if (!mem_addr_ok) begin
                     state_d = ST_HOLD;
                     owner_d = sel;
                  end
               end
            end
            ST_HOLD: begin
               sel = owner_q;
               if (owner_req) begin
                  grant = 1'b1;
                  if (mem_addr_ok) state_d = ST_IDLE;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   assign req_out   = !grant ? '0 : ((sel == ID_DATA) ? req_data : req_inst);
   assign mem_req   = grant;
   assign mem_wr    = req_out.wr;
   assign mem_size  = req_out.size;
   assign mem_wstrb = req_out.wstrb;
   assign mem_addr  = req_out.addr;
   assign mem_wdata = req_out.wdata;

   assign push         = grant & mem_addr_ok;
   assign inst_addr_ok = push & (sel == ID_INST);
   assign data_addr_ok = push & (sel == ID_DATA);

   assign pop          = resetn & mem_data_ok & ~fifo_empty;
   assign inst_data_ok = pop & (fifo_dout == ID_INST);
   assign data_data_ok = pop & (fifo_dout == ID_DATA);
   assign inst_rdata   = mem_rdata;
   assign data_rdata   = mem_rdata;

   // Responses for requests abandoned by reset land on an empty FIFO.
   always_ff @(posedge clk) begin
      if (!resetn)                        resp_err <= 1'b0;
      else if (mem_data_ok && fifo_empty) resp_err <= 1'b1;
   end

   resp_id_fifo #(
      .DEPTH (OUTSTANDING)
   ) u_resp_id_fifo (
      .clk    (clk),
      .resetn (resetn),
      .push   (push),
      .pop    (pop),
      .din    (sel),
      .dout   (fifo_dout),
      .full   (fifo_full),
      .empty  (fifo_empty)
   );

endmodule
